// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// uart_rx_ctrl : UART receive control - start detect, bit timing, parity/stop
//                checking, buffer handshake and error flags.   Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic parity_error,
  output logic overrun_error,
  output logic busy
);

  localparam int            c_tw        = $clog2(CLKS_PER_BIT);
  localparam logic [c_tw-1:0] c_tc      = c_tw'(CLKS_PER_BIT - 1);
  localparam logic [c_tw-1:0] c_half_tc = c_tw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    c_last_bit  = 4'(DATA_BITS - 1);
  localparam logic          c_last_stop = (STOP_BITS == 2);
  localparam logic          c_odd       = (PARITY_MODE == 2);
  localparam logic          c_has_par   = (PARITY_MODE != 0);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;
  localparam logic [2:0] c_st_wait   = 3'd5;
  localparam logic [2:0] c_st_load   = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [c_tw-1:0] timer_q, timer_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic            acc_q, acc_d;
  logic            data_ready_q, data_ready_d;
  logic            framing_error_q, framing_error_d;
  logic            parity_error_q, parity_error_d;
  logic            overrun_error_q, overrun_error_d;

  logic w_tc, w_half_tc, w_timing, w_valid_start, w_strobe, w_load;

  assign w_tc          = (timer_q == c_tc);
  assign w_half_tc     = (timer_q == c_half_tc);
  assign w_timing      = (state_q == c_st_start) || (state_q == c_st_data) ||
                         (state_q == c_st_parity) || (state_q == c_st_stop);
  assign w_valid_start = (state_q == c_st_start) && w_half_tc && !serial_in;
  assign w_strobe      = (state_q == c_st_data) && w_tc;
  assign w_load        = (state_q == c_st_load);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= c_st_idle;
      timer_q         <= '0;
      bit_cnt_q       <= '0;
      stop_cnt_q      <= 1'b0;
      acc_q           <= 1'b0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      bit_cnt_q       <= bit_cnt_d;
      stop_cnt_q      <= stop_cnt_d;
      acc_q           <= acc_d;
      data_ready_q    <= data_ready_d;
      framing_error_q <= framing_error_d;
      parity_error_q  <= parity_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:   if (!serial_in) state_d = c_st_start;
      c_st_start:  if (w_half_tc) state_d = serial_in ? c_st_idle : c_st_data;
      c_st_data:   if (w_tc && (bit_cnt_q == c_last_bit))
                     state_d = c_has_par ? c_st_parity : c_st_stop;
      c_st_parity: if (w_tc) state_d = c_st_stop;
      c_st_stop: begin
        if (w_tc) begin
          if (!serial_in)                      state_d = c_st_wait;
          else if (stop_cnt_q == c_last_stop)  state_d = c_st_load;
        end
      end
      // A line stuck low after a bad stop bit must rise before a new start counts
      c_st_wait:   if (serial_in) state_d = c_st_idle;
      c_st_load:   state_d = c_st_idle;
      default:     state_d = c_st_idle;
    endcase
  end

  always_comb begin
    timer_d         = timer_q + 1'b1;
    bit_cnt_d       = bit_cnt_q;
    stop_cnt_d      = stop_cnt_q;
    acc_d           = acc_q;
    framing_error_d = framing_error_q;
    parity_error_d  = parity_error_q;
    data_ready_d    = data_ready_q;
    overrun_error_d = overrun_error_q;

    if (!w_timing || (state_d != state_q) || w_tc) timer_d = '0;

    if (w_valid_start) begin
      bit_cnt_d       = '0;
      stop_cnt_d      = 1'b0;
      acc_d           = 1'b0;
      framing_error_d = 1'b0;
      parity_error_d  = 1'b0;
    end

    if (w_strobe) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      acc_d     = acc_q ^ serial_in;
    end

    if ((state_q == c_st_parity) && w_tc && ((acc_q ^ serial_in) != c_odd))
      parity_error_d = 1'b1;

    if ((state_q == c_st_stop) && w_tc) begin
      if (!serial_in) framing_error_d = 1'b1;
      else            stop_cnt_d      = ~stop_cnt_q;
    end

    // A read coinciding with a load consumes the old frame, so no overrun
    if (w_load)         data_ready_d = 1'b1;
    else if (data_read) data_ready_d = 1'b0;

    if (w_load && data_ready_q && !data_read) overrun_error_d = 1'b1;
    else if (data_read)                       overrun_error_d = 1'b0;
  end

  always_comb begin
    shift_strobe = w_strobe;
    load_buffer  = w_load;
    busy         = (state_q != c_st_idle);
  end

  assign data_ready    = data_ready_q;
  assign framing_error = framing_error_q;
  assign parity_error  = parity_error_q;
  assign overrun_error = overrun_error_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// tb_uart_rx_ctrl : scoreboard bench for uart_rx_ctrl (8N1 and 7E1 instances)
//                   Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ser = 2'b11;
  logic [1:0] rd  = 2'b00;
  logic [1:0] strobe, ld, dr, fe, pe, oe, busy;

  always #5 clk = ~clk;

  uart_rx_ctrl u0 (
    .clk(clk), .rst(rst), .serial_in(ser[0]), .data_read(rd[0]),
    .shift_strobe(strobe[0]), .load_buffer(ld[0]), .data_ready(dr[0]),
    .framing_error(fe[0]), .parity_error(pe[0]), .overrun_error(oe[0]),
    .busy(busy[0])
  );

  uart_rx_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .serial_in(ser[1]), .data_read(rd[1]),
    .shift_strobe(strobe[1]), .load_buffer(ld[1]), .data_ready(dr[1]),
    .framing_error(fe[1]), .parity_error(pe[1]), .overrun_error(oe[1]),
    .busy(busy[1])
  );

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       ov;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   strobe_total[2] = '{0, 0};

  function automatic int nbits(input int i);
    return (i == 0) ? 8 : 7;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int i, input logic [15:0] f, input int n);
    for (int k = 0; k < n; k++) begin
      ser[i] = f[k];
      repeat (10) tick();
    end
  endtask

  task automatic send_frame(input int i, input logic [8:0] d, input int nb,
                            input bit pen, input bit pbit, input bit stopv);
    logic [15:0] f;
    int          n;
    f    = '1;
    f[0] = 1'b0;
    n    = 1;
    for (int k = 0; k < nb; k++) begin
      f[n] = d[k];
      n++;
    end
    if (pen) begin
      f[n] = pbit;
      n++;
    end
    f[n] = stopv;
    n++;
    send_bits(i, f, n);
  endtask

  task automatic check_quiet(input int i, input string name);
    check(name, {25'd0, strobe[i], ld[i], dr[i], fe[i], pe[i], oe[i], busy[i]}, 32'd0);
  endtask

  // Monitor: rebuilds each frame from serial_in at every strobe and scores it at load
  initial begin
    int         start_c[2];
    int         last_s[2];
    int         nstrb[2];
    logic [8:0] sh[2];
    logic       post[2];
    logic       post_ov[2];
    logic       busy_p[2];
    exp_t       e;
    logic [8:0] got;
    for (int i = 0; i < 2; i++) begin
      start_c[i] = 0; last_s[i] = 0; nstrb[i] = 0; sh[i] = '0;
      post[i] = 1'b0; post_ov[i] = 1'b0; busy_p[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (post[i]) begin
          check($sformatf("data_ready_after_load%0d", i), 32'(dr[i]), 32'd1);
          check($sformatf("overrun_after_load%0d", i), 32'(oe[i]), 32'(post_ov[i]));
          post[i] = 1'b0;
        end
        if (busy[i] && !busy_p[i]) begin
          start_c[i] = cyc;
          nstrb[i]   = 0;
          sh[i]      = '0;
        end
        busy_p[i] = busy[i];
        if (strobe[i]) begin
          if (nstrb[i] > 0)
            check($sformatf("strobe_spacing%0d", i), 32'(cyc - last_s[i]), 32'd10);
          last_s[i] = cyc;
          sh[i]     = {ser[i], sh[i][8:1]};
          nstrb[i]++;
          strobe_total[i]++;
        end
        if (ld[i]) begin
          if (((i == 0) ? q0.size() : q1.size()) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_load%0d: got load_buffer=1 expected no load (t=%0t)", i, $time);
          end else begin
            e   = (i == 0) ? q0.pop_front() : q1.pop_front();
            got = sh[i] >> (9 - nbits(i));
            check($sformatf("load_data%0d", i), 32'(got), 32'(e.d));
            check($sformatf("load_latency%0d", i), 32'(cyc - start_c[i]), 32'd95);
            check($sformatf("strobe_count%0d", i), 32'(nstrb[i]), 32'(nbits(i)));
            check($sformatf("parity_err_at_load%0d", i), 32'(pe[i]), 32'(e.pe));
            check($sformatf("framing_err_at_load%0d", i), 32'(fe[i]), 32'd0);
            post[i]    = 1'b1;
            post_ov[i] = e.ov;
          end
        end
      end
    end
  end

  initial begin
    int s;
    int nb;
    exp_t e;

    // Reset state
    repeat (3) tick();
    check_quiet(0, "reset_outputs0");
    check_quiet(1, "reset_outputs1");
    rst = 1'b0;
    tick();
    check_quiet(0, "post_reset_idle0");

    // Clean 8N1 frame 0xA5
    e = '{d: 9'h0A5, pe: 1'b0, ov: 1'b0};
    q0.push_back(e);
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check("ready_after_a5", 32'(dr[0]), 32'd1);
    check("flags_after_a5", {29'd0, fe[0], pe[0], oe[0]}, 32'd0);
    rd[0] = 1'b1;
    tick();
    rd[0] = 1'b0;
    check("ready_cleared_by_read", 32'(dr[0]), 32'd0);

    // Start-bit glitch of 3 cycles
    s  = strobe_total[0];
    nb = 0;
    ser[0] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (busy[0]) nb++;
      if (k == 3) ser[0] = 1'b1;
    end
    check("glitch_busy_cycles", 32'(nb), 32'd5);
    check("glitch_no_strobes", 32'(strobe_total[0] - s), 32'd0);
    check("glitch_no_ready", 32'(dr[0]), 32'd0);

    // Low stop bit, line held low for 30 more cycles
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
    repeat (30) tick();
    check("framing_err_set", 32'(fe[0]), 32'd1);
    check("wait_high_busy", 32'(busy[0]), 32'd1);
    check("framing_no_load", 32'(dr[0]), 32'd0);
    ser[0] = 1'b1;
    repeat (2) tick();
    check("wait_high_release", 32'(busy[0]), 32'd0);
    nb = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (busy[0]) nb++;
    end
    check("no_false_start", 32'(nb), 32'd0);
    check("framing_err_held", 32'(fe[0]), 32'd1);

    // Back-to-back frames without reading: overrun on the second
    e = '{d: 9'h00F, pe: 1'b0, ov: 1'b0};
    q0.push_back(e);
    send_frame(0, 9'h00F, 8, 1'b0, 1'b0, 1'b1);
    e = '{d: 9'h0F0, pe: 1'b0, ov: 1'b1};
    q0.push_back(e);
    send_frame(0, 9'h0F0, 8, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    check("overrun_sticky", 32'(oe[0]), 32'd1);
    rd[0] = 1'b1;
    tick();
    rd[0] = 1'b0;
    check("read_clears_ready", 32'(dr[0]), 32'd0);
    check("read_clears_overrun", 32'(oe[0]), 32'd0);

    // 7E1: 0x55 with wrong parity, then correct parity
    e = '{d: 9'h055, pe: 1'b1, ov: 1'b0};
    q1.push_back(e);
    send_frame(1, 9'h055, 7, 1'b1, 1'b1, 1'b1);
    repeat (2) tick();
    check("parity_err_held", 32'(pe[1]), 32'd1);
    rd[1] = 1'b1;
    tick();
    rd[1] = 1'b0;
    e = '{d: 9'h055, pe: 1'b0, ov: 1'b0};
    q1.push_back(e);
    fork
      send_frame(1, 9'h055, 7, 1'b1, 1'b0, 1'b1);
      begin
        repeat (20) tick();
        check("parity_err_cleared_at_start", 32'(pe[1]), 32'd0);
      end
    join
    repeat (2) tick();
    check("parity_err_stays_clear", 32'(pe[1]), 32'd0);
    rd[1] = 1'b1;
    tick();
    rd[1] = 1'b0;

    // Reset after three data strobes, then a full frame
    s = strobe_total[0];
    send_bits(0, {7'h7F, 8'h5A, 1'b0}, 4);
    check("strobes_before_reset", 32'(strobe_total[0] - s), 32'd3);
    rst    = 1'b1;
    ser[0] = 1'b1;
    tick();
    check_quiet(0, "mid_frame_reset0");
    rst = 1'b0;
    repeat (12) tick();
    check_quiet(0, "reset_abort_no_load");
    e = '{d: 9'h05A, pe: 1'b0, ov: 1'b0};
    q0.push_back(e);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);

    repeat (20) tick();
    check("all_loads_seen0", 32'(q0.size()), 32'd0);
    check("all_loads_seen1", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised receiver control unit for the UART receive path. It replaces the external start-detect, timer and stop-bit checker with an internal bit-period timer and bit counter. It adds configurable data width, optional even/odd parity, 1 or 2 stop bits, start-bit glitch rejection, and a data_ready/data_read handshake with overrun detection. It sits between the input synchroniser (serial_in is already synchronised) and the receive shift register/buffer.

Parameters:
CLKS_PER_BIT, 10, clock cycles per bit period; must be at least 4.
DATA_BITS, 8, data bits per frame, 5..9, LSB first.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
serial_in  input  1  synchronised serial line, idle high
data_read  input  1  consumer acknowledges the buffered byte
shift_strobe  output  1  one-cycle pulse at each data-bit mid-point; shift register samples serial_in
load_buffer  output  1  one-cycle pulse; shift register contents copied to the rx buffer
data_ready  output  1  buffer holds an unread frame
framing_error  output  1  last frame had a low stop bit
parity_error  output  1  last frame had a parity mismatch
overrun_error  output  1  a frame was loaded while data_ready was 1 and not being read
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst high at a clk edge): state IDLE; timer, bit counter and parity accumulator at 0; all outputs 0. Reset mid-frame aborts the frame with no load and no flags.
- HALF = CLKS_PER_BIT/2, truncated. Timer terminal count (TC) means timer == period-1. The timer resets to 0 on every state change and after every TC.
- IDLE: serial_in==0 -> START.
- START: count HALF cycles. At timer==HALF-1:
  - serial_in==0: valid start -> DATA; clear parity_error, framing_error, bit counter and parity accumulator.
  - serial_in==1: glitch -> IDLE; no flags change.
- DATA: shift_strobe=1 during each TC cycle. On each strobe, bit counter +1 and accumulator ^= serial_in. After strobe number DATA_BITS -> PARITY if PARITY_MODE!=0, else STOP.
- PARITY: at TC, parity_error is set if (acc ^ serial_in) != (PARITY_MODE==2), then -> STOP. No shift_strobe is issued for the parity bit.
- STOP: one period per stop bit. At each TC:
  - serial_in==0: set framing_error -> WAIT_HIGH; no load.
  - serial_in==1 on the last stop bit -> LOAD.
- WAIT_HIGH: stay until serial_in==1, then -> IDLE. This prevents a held-low line being taken as a new start.
- LOAD: load_buffer=1 for exactly one cycle, then -> IDLE. The frame is loaded even when parity_error is set.
- data_ready:
  - Set the cycle after LOAD.
  - Cleared by data_read when no load is occurring in the same cycle.
  - Load and data_read in the same cycle: data_ready stays 1 and there is no overrun.
- overrun_error:
  - Set at LOAD if data_ready==1 and data_read==0; the buffer is overwritten.
  - Sticky until a data_read cycle with no coincident overrun.
- framing_error and parity_error hold their value until the next valid start.
- Outputs are registered or decoded directly from state/timer; there are no combinational paths from serial_in to outputs.
- Frame latency from entering START to load_buffer = HALF + CLKS_PER_BIT*(DATA_BITS + (PARITY_MODE!=0) + STOP_BITS).

Test Plan:
- Defaults (10 clks, 8N1), send 0xA5 LSB first with a clean stop bit -> 8 shift_strobe pulses spaced 10 cycles apart; load_buffer exactly 95 cycles after START entry; data_ready=1; all error flags 0.
- serial_in low for 3 cycles only, then high -> START returns to IDLE at timer==4; no strobes, no load; busy drops after 5 cycles.
- Stop bit driven low, line held low for 30 more cycles -> framing_error=1, no load_buffer; FSM stays in WAIT_HIGH until the line rises; no false start while low.
- PARITY_MODE=1, DATA_BITS=7, send 0x55 with parity bit 1 (wrong) -> load_buffer pulses once and parity_error=1; next frame 0x55 with parity 0 -> parity_error clears at its valid start and stays 0.
- Two frames back to back with data_read never asserted -> overrun_error=1 at the second LOAD; then data_read pulse -> data_ready=0 and overrun_error=0.
- Assert rst mid-DATA (after 3 strobes) -> next cycle all outputs 0 and state IDLE; a following full frame receives correctly.
